// File: rtl/cmp_drv_pkg.sv
// Shared types and constants for the comparator vector driver.
package cmp_drv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      FINISH = 2'd3
   } state_e;

   localparam int unsigned VEC_W             = 4;
   localparam int unsigned N_VEC             = 256;
   localparam int unsigned DEF_SETTLE_CYCLES = 2;
   localparam int unsigned DEF_ERR_W         = 8;

endpackage

// File: rtl/cmp_drv_vecgen.sv
// Vector index generator: owns idx, maps it onto the a/b operands and flags the last vector.
module cmp_drv_vecgen
   import cmp_drv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [VEC_W-1:0] a_o,
   output logic [VEC_W-1:0] b_o,
   output logic             last_o
);

   logic [2*VEC_W-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (inc_i) begin
         idx_d = idx_q + (2*VEC_W)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign a_o    = idx_q[2*VEC_W-1:VEC_W];
   assign b_o    = idx_q[VEC_W-1:0];
   assign last_o = (idx_q == (2*VEC_W)'(N_VEC - 1));

endmodule

// File: rtl/cmp_vector_driver.sv
// Exhaustive 4-bit equality-comparator sweep driver with settle timing and mismatch counting.
// Optional first-mismatch capture on fail_vec is enabled by defining CMP_DRV_FAIL_CAPTURE_EN.
module cmp_vector_driver
   import cmp_drv_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned ERR_W         = DEF_ERR_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [VEC_W-1:0] a,
   output logic [VEC_W-1:0] b,
   input  logic             equal,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_vec
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic vec_clr, vec_inc, vec_last;
   logic accept, mismatch;

   cmp_drv_vecgen u_vecgen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (vec_clr),
      .inc_i  (vec_inc),
      .a_o    (a),
      .b_o    (b),
      .last_o (vec_last)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
      vec_clr  = 1'b0;
      vec_inc  = 1'b0;
      accept   = 1'b0;
      mismatch = 1'b0;
      unique case (state_q)
         IDLE: begin
            // done is registered, so the done cycle is already IDLE; a start there is refused
            if (start && !done_q) begin
               accept  = 1'b1;
               vec_clr = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               err_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CHECK: begin
            mismatch = (equal != (a == b));
            if (mismatch && (err_q != '1)) begin
               err_d = err_q + ERR_W'(1);
            end
            cnt_d = '0;
            if (vec_last) begin
               state_d = FINISH;
            end else begin
               vec_inc = 1'b1;
               state_d = SETTLE;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
      end
   end

`ifdef CMP_DRV_FAIL_CAPTURE_EN
   logic [7:0] fail_vec_q, fail_vec_d;

   always_comb begin
      fail_vec_d = fail_vec_q;
      if (accept) begin
         fail_vec_d = '0;
      end else if (mismatch && (err_q == '0)) begin
         fail_vec_d = {a, b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_vec_q <= '0;
      end else begin
         fail_vec_q <= fail_vec_d;
      end
   end

   assign fail_vec = fail_vec_q;
`else
   assign fail_vec = '0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_cmp_vector_driver.sv
// Self-checking bench for cmp_vector_driver: directed sweeps with randomized fault sets.
module tb_cmp_vector_driver;

   localparam int unsigned S       = 2;
   localparam int unsigned LAT     = 256 * (S + 1) + 1;
   localparam int unsigned TIMEOUT = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       equal;
   logic [3:0] a, b;
   logic       busy, done, pass;
   logic [7:0] err_count;
   logic [7:0] fail_vec;

   logic       s_start = 1'b0;
   logic       s_equal = 1'b1;
   logic [3:0] s_a, s_b;
   logic       s_busy, s_done, s_pass;
   logic [3:0] s_err;
   logic [7:0] s_fail;

   int unsigned   eq_mode = 0;
   logic [255:0]  fault_mask = '0;

   int unsigned vectors = 0;
   int unsigned errs    = 0;

   cmp_vector_driver #(.SETTLE_CYCLES(S), .ERR_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .equal(equal),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
   );

   cmp_vector_driver #(.SETTLE_CYCLES(S), .ERR_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .equal(s_equal),
      .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err), .fail_vec(s_fail)
   );

   always #5 clk = ~clk;

   // Comparator stand-in: 0 = ideal with per-vector faults, 1 = stuck at 0, 2 = stuck at 1
   always_comb begin
      case (eq_mode)
         1:       equal = 1'b0;
         2:       equal = 1'b1;
         default: equal = (a == b) ^ fault_mask[{a, b}];
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk all 256 vectors, count where the stand-in disagrees with a==b
   task automatic model(input int unsigned max_err, output int unsigned exp_err,
                        output logic [7:0] exp_fail);
      int unsigned cnt = 0;
      bit          first = 1'b0;
      exp_fail = 8'h00;
      for (int unsigned v = 0; v < 256; v++) begin
         int unsigned ra = v / 16;
         int unsigned rb = v % 16;
         bit truth = (ra == rb);
         bit drv;
         case (eq_mode)
            1:       drv = 1'b0;
            2:       drv = 1'b1;
            default: drv = truth ^ fault_mask[v];
         endcase
         if (drv != truth) begin
            if (cnt < max_err) cnt++;
            if (!first) begin
               first = 1'b1;
`ifdef CMP_DRV_FAIL_CAPTURE_EN
               exp_fail = 8'(v);
`endif
            end
         end
      end
      exp_err = cnt;
   endtask

   // Called #1 after an edge while idle; the following edge accepts start.
   task automatic sweep(input bit kicks, input bit chk_ab, input bit sat,
                        output int unsigned lat);
      int unsigned k = 0;
      bit seen = 1'b0;
      start = 1'b1;
      s_start = sat;
      @(posedge clk); #1;
      start = 1'b0;
      s_start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("err_cleared", {24'd0, err_count}, 32'd0);
      chk("pass_cleared", {31'd0, pass}, 32'd0);
      while (!seen && k < TIMEOUT) begin
         if (chk_ab) begin
            int unsigned idx = k / (S + 1);
            if (idx > 255) idx = 255;
            chk("ab_sequence", {24'd0, a, b}, idx);
         end
         start = (kicks && (k == 10 || k == 400));
         @(posedge clk); #1;
         k++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      lat = k;
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_and_check(input string tag, input bit kicks, input bit chk_ab,
                                input bit sat);
      int unsigned lat, exp_err;
      logic [7:0]  exp_fail;
      model(255, exp_err, exp_fail);
      sweep(kicks, chk_ab, sat, lat);
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_err_count"}, {24'd0, err_count}, exp_err);
      chk({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_err == 0});
      chk({tag, "_fail_vec"}, {24'd0, fail_vec}, {24'd0, exp_fail});
   endtask

   task automatic reset_outputs_zero(input string tag);
      chk({tag, "_outs"}, {24'd0, a, b, busy, done, pass, 5'd0}, 32'd0);
      chk({tag, "_err"}, {24'd0, err_count}, 32'd0);
      chk({tag, "_fail"}, {24'd0, fail_vec}, 32'd0);
      chk({tag, "_sat_outs"}, {s_a, s_b, s_busy, s_done, s_pass, s_err, s_fail, 9'd0}, 32'd0);
   endtask

   initial begin
      int unsigned any;
      int unsigned n;

      // reset held for 3 cycles
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_outputs_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fault-free sweep with full a/b progression check
      eq_mode = 0; fault_mask = '0;
      run_and_check("clean", 1'b0, 1'b1, 1'b0);

      // stuck-at-0, with the saturating ERR_W=4 instance sweeping alongside on stuck-at-1
      eq_mode = 1;
      run_and_check("stuck0", 1'b0, 1'b0, 1'b1);
      chk("sat_err_count", {28'd0, s_err}, 32'hF);
      chk("sat_pass", {31'd0, s_pass}, 32'd0);

      // single fault at C/D
      eq_mode = 0; fault_mask = '0; fault_mask[8'hCD] = 1'b1;
      run_and_check("single_cd", 1'b0, 1'b0, 1'b0);

      // randomized fault sets
      for (int r = 0; r < 3; r++) begin
         fault_mask = '0;
         n = $urandom_range(0, 6);
         for (int unsigned i = 0; i < n; i++) fault_mask[$urandom_range(0, 255)] = 1'b1;
         run_and_check("random", 1'b0, 1'b0, 1'b0);
      end

      // start pulses mid-sweep must not restart or add a sweep
      fault_mask = '0;
      run_and_check("kicks", 1'b1, 1'b0, 1'b0);
      any = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) any++;
      end
      chk("kicks_no_second_sweep", any, 0);

      // asynchronous reset at cycle 300 aborts the sweep
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (299) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      reset_outputs_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      any = 0;
      repeat (800) begin
         @(posedge clk); #1;
         if (done || busy) any++;
      end
      chk("midreset_no_done", any, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
